// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file port controller.
package rf_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREG   = 16;
   localparam int unsigned ADDR_W = 4;

   // Writeback requesters sharing the single write port.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

   // R0 reads as zero and ignores writes.
   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rf_addr_decoder.sv
// Register address to one-hot enable decoder; all zeros when disabled.
module rf_addr_decoder
   import rf_pkg::*;
(
   input  logic              en_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [NREG-1:0]   onehot_o
);

   // One-hot expansion of the address, gated by the enable.
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[addr_i] = 1'b1;
      end
   end

endmodule

// File: rtl/rf_port_ctrl.sv
// Register-file port controller: round-robin arbitration of the ALU and
// memory-load writeback requesters onto the single write port, a one-cycle
// write stage, one-hot enable generation and read-data return.
// Optional macro RF_BYPASS_EN forwards the staged write to matching reads.
module rf_port_ctrl
   import rf_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alu_wr_valid_i,
   output logic              alu_wr_ready_o,
   input  logic [ADDR_W-1:0] alu_wr_addr_i,
   input  logic [DATA_W-1:0] alu_wr_data_i,
   input  logic              mem_wr_valid_i,
   output logic              mem_wr_ready_o,
   input  logic [ADDR_W-1:0] mem_wr_addr_i,
   input  logic [DATA_W-1:0] mem_wr_data_i,
   input  logic [ADDR_W-1:0] rd1_addr_i,
   input  logic [ADDR_W-1:0] rd2_addr_i,
   output logic [DATA_W-1:0] rd1_data_o,
   output logic [DATA_W-1:0] rd2_data_o,
   output logic [NREG-1:0]   rf_wen_o,
   output logic [DATA_W-1:0] rf_wdata_o,
   output logic [NREG-1:0]   rf_ren1_o,
   output logic [NREG-1:0]   rf_ren2_o,
   input  logic [DATA_W-1:0] rf_bl1_i,
   input  logic [DATA_W-1:0] rf_bl2_i,
   output logic [NREG-1:0]   busy_o
);

   req_e              last_grant_q, last_grant_d;
   logic              stg_valid_q, stg_valid_d;
   logic [ADDR_W-1:0] stg_addr_q, stg_addr_d;
   logic [DATA_W-1:0] stg_data_q, stg_data_d;
   logic              alu_win;
   logic              stg_live;

   // Round-robin grant, ready handshake and stage next-state.
   always_comb begin
      alu_win        = alu_wr_valid_i & (~mem_wr_valid_i | (last_grant_q == REQ_MEM));
      alu_wr_ready_o = ~rst_i & alu_win;
      mem_wr_ready_o = ~rst_i & mem_wr_valid_i & ~alu_win;
      last_grant_d   = last_grant_q;
      stg_valid_d    = 1'b0;
      stg_addr_d     = '0;
      stg_data_d     = '0;
      if (alu_wr_ready_o) begin
         last_grant_d = REQ_ALU;
         stg_valid_d  = 1'b1;
         stg_addr_d   = alu_wr_addr_i;
         stg_data_d   = alu_wr_data_i;
      end else if (mem_wr_ready_o) begin
         last_grant_d = REQ_MEM;
         stg_valid_d  = 1'b1;
         stg_addr_d   = mem_wr_addr_i;
         stg_data_d   = mem_wr_data_i;
      end
   end

   // Stage and grant-pointer registers; pointer resets to MEM so ALU wins the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant_q <= REQ_MEM;
         stg_valid_q  <= 1'b0;
         stg_addr_q   <= '0;
         stg_data_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         stg_valid_q  <= stg_valid_d;
         stg_addr_q   <= stg_addr_d;
         stg_data_q   <= stg_data_d;
      end
   end

   // A staged write is dropped in a reset cycle and never targets R0.
   assign stg_live   = stg_valid_q & ~rst_i & (stg_addr_q != ZERO_REG);
   assign busy_o     = rf_wen_o;
   assign rf_wdata_o = stg_data_q;

   rf_addr_decoder u_wr_dec (
      .en_i     (stg_live),
      .addr_i   (stg_addr_q),
      .onehot_o (rf_wen_o)
   );

   rf_addr_decoder u_rd1_dec (
      .en_i     (1'b1),
      .addr_i   (rd1_addr_i),
      .onehot_o (rf_ren1_o)
   );

   rf_addr_decoder u_rd2_dec (
      .en_i     (1'b1),
      .addr_i   (rd2_addr_i),
      .onehot_o (rf_ren2_o)
   );

   // Read return: bitlines, optional forwarding of the staged write, R0 forced to zero.
   always_comb begin
      rd1_data_o = rf_bl1_i;
      rd2_data_o = rf_bl2_i;
`ifdef RF_BYPASS_EN
      if (stg_live && (rd1_addr_i == stg_addr_q)) begin
         rd1_data_o = stg_data_q;
      end
      if (stg_live && (rd2_addr_i == stg_addr_q)) begin
         rd2_data_o = stg_data_q;
      end
`endif
      if (rd1_addr_i == ZERO_REG) begin
         rd1_data_o = '0;
      end
      if (rd2_addr_i == ZERO_REG) begin
         rd2_data_o = '0;
      end
   end

endmodule
